// File: rtl/rs_wakeup_matrix_pkg.sv
// Shared constants and types for the RS wakeup matrix.
// Provides default sizing, index/latency types and the variable-latency code.
package rs_wakeup_matrix_pkg;

    localparam int RS_ENTRIES = 16;
    localparam int RS_IDX_W   = $clog2(RS_ENTRIES);
    localparam int RS_SRCS    = 2;
    localparam int LAT_W      = 4;

    typedef logic [RS_IDX_W-1:0] rs_idx_t;
    typedef logic [LAT_W-1:0]    lat_t;

    // A latency of zero marks a producer that completes via done_valid.
    localparam lat_t LAT_VARIABLE = '0;

endpackage

// File: rtl/rs_wakeup_matrix_if.sv
// Dispatch / select / completion / release bundle of the RS wakeup matrix.
// master drives requests and events, slave (the matrix) returns status.
interface rs_wakeup_matrix_if #(
    parameter int NUM_ENTRIES = rs_wakeup_matrix_pkg::RS_ENTRIES,
    parameter int NUM_SRCS    = rs_wakeup_matrix_pkg::RS_SRCS,
    parameter int LAT_W       = rs_wakeup_matrix_pkg::LAT_W
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic                      flush;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [IDX_W-1:0]          disp_idx;
    logic [NUM_SRCS-1:0]       disp_dep_valid;
    logic [NUM_SRCS*IDX_W-1:0] disp_dep_idx;
    logic [LAT_W-1:0]          disp_latency;
    logic [NUM_ENTRIES-1:0]    req_vec;
    logic                      grant_valid;
    logic [IDX_W-1:0]          grant_idx;
    logic                      done_valid;
    logic [IDX_W-1:0]          done_idx;
    logic                      free_valid;
    logic [IDX_W-1:0]          free_idx;
    logic [IDX_W:0]            num_free;
    logic                      err;

    modport master (
        output flush, disp_valid, disp_dep_valid, disp_dep_idx,
        output disp_latency, grant_valid, grant_idx,
        output done_valid, done_idx, free_valid, free_idx,
        input  disp_ready, disp_idx, req_vec, num_free, err
    );

    modport slave (
        input  flush, disp_valid, disp_dep_valid, disp_dep_idx,
        input  disp_latency, grant_valid, grant_idx,
        input  done_valid, done_idx, free_valid, free_idx,
        output disp_ready, disp_idx, req_vec, num_free, err
    );

endinterface

// File: rtl/rs_wakeup_matrix_countdown.sv
// Per-entry latency countdown: fires the broadcast of a fixed-latency producer.
// Ports: clk, rst, clr (kill), load+lat (grant), fire (broadcast this cycle).
module rs_wakeup_matrix_countdown #(
    parameter int LAT_W = rs_wakeup_matrix_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic             fire
);
    logic [LAT_W-1:0] cnt_q;
    logic             counting_q;
    logic             active;
    logic [LAT_W-1:0] cnt_now;

    // The grant cycle already counts as lat-1, so lat==1 fires at once
    // and a grant at t with latency L fires at t+L-1.
    assign active  = load | counting_q;
    assign cnt_now = load ? lat - LAT_W'(1) : cnt_q;
    assign fire    = active & ~clr & (cnt_now == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q      <= '0;
            counting_q <= 1'b0;
        end else if (fire) begin
            cnt_q      <= '0;
            counting_q <= 1'b0;
        end else if (active) begin
            cnt_q      <= cnt_now - LAT_W'(1);
            counting_q <= 1'b1;
        end
    end

endmodule

// File: rtl/rs_wakeup_matrix.sv
// Entry-indexed RS wakeup matrix producing the select request vector.
// Ports: clk, rst (sync, active-high), io (slave side of rs_wakeup_matrix_if).
module rs_wakeup_matrix #(
    parameter int NUM_ENTRIES = rs_wakeup_matrix_pkg::RS_ENTRIES,
    parameter int NUM_SRCS    = rs_wakeup_matrix_pkg::RS_SRCS,
    parameter int LAT_W       = rs_wakeup_matrix_pkg::LAT_W,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input logic             clk,
    input logic             rst,
    rs_wakeup_matrix_if.slave io
);
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] sel_q;
    logic [NUM_ENTRIES-1:0] rel_q;
    logic [NUM_ENTRIES-1:0] row_q [NUM_ENTRIES];
    logic [LAT_W-1:0]       lat_q [NUM_ENTRIES];
    logic [IDX_W:0]         num_free_q;
    logic                   err_q;

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   live;
    logic                   grant_legal;
    logic                   done_legal;
    logic                   free_legal;
    logic                   alloc;
    logic                   protocol_err;
    logic [NUM_ENTRIES-1:0] alloc_oh;
    logic [NUM_ENTRIES-1:0] grant_oh;
    logic [NUM_ENTRIES-1:0] done_oh;
    logic [NUM_ENTRIES-1:0] free_oh;
    logic [NUM_ENTRIES-1:0] load;
    logic [NUM_ENTRIES-1:0] fire;
    logic [NUM_ENTRIES-1:0] bcast;
    logic [NUM_ENTRIES-1:0] clear_col;
    logic [NUM_ENTRIES-1:0] new_row;
    logic [IDX_W-1:0]       prod;

    assign free_vec = ~valid_q;

    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign io.disp_ready = |free_vec;
    assign io.disp_idx   = alloc_idx;
    assign io.num_free   = num_free_q;
    assign io.err        = err_q;

    assign live = ~io.flush;

    assign grant_legal = valid_q[io.grant_idx] & ~sel_q[io.grant_idx];
    assign done_legal  = valid_q[io.done_idx] & sel_q[io.done_idx]
                       & ~rel_q[io.done_idx]
                       & (lat_q[io.done_idx] == '0);
    assign free_legal  = valid_q[io.free_idx];

    assign alloc = live & io.disp_valid & io.disp_ready;

    assign protocol_err = (io.disp_valid & ~io.disp_ready)
                        | (io.grant_valid & ~grant_legal)
                        | (io.done_valid & ~done_legal)
                        | (io.free_valid & ~free_legal);

    assign alloc_oh = alloc ? NUM_ENTRIES'(1) << alloc_idx : '0;
    assign grant_oh = (live & io.grant_valid & grant_legal)
                    ? NUM_ENTRIES'(1) << io.grant_idx : '0;
    assign done_oh  = (live & io.done_valid & done_legal)
                    ? NUM_ENTRIES'(1) << io.done_idx : '0;
    assign free_oh  = (live & io.free_valid & free_legal)
                    ? NUM_ENTRIES'(1) << io.free_idx : '0;

    // A freed entry neither starts counting nor broadcasts: free wins.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            load[i] = grant_oh[i] & ~free_oh[i] & (lat_q[i] != '0);
        end
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cd
        rs_wakeup_matrix_countdown #(
            .LAT_W (LAT_W)
        ) u_cd (
            .clk  (clk),
            .rst  (rst),
            .clr  (io.flush | free_oh[i]),
            .load (load[i]),
            .lat  (lat_q[i]),
            .fire (fire[i])
        );
    end

    assign bcast     = fire | (done_oh & ~free_oh);
    assign clear_col = bcast | free_oh;

    // Producers that broadcast or leave this cycle are bypassed.
    always_comb begin
        new_row = '0;
        prod    = '0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            prod = io.disp_dep_idx[s*IDX_W +: IDX_W];
            if (io.disp_dep_valid[s] && valid_q[prod]
                && !rel_q[prod] && !clear_col[prod]) begin
                new_row[prod] = 1'b1;
            end
        end
    end

    always_comb begin
        io.req_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            io.req_vec[i] = valid_q[i] & ~sel_q[i] & (row_q[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || io.flush) begin
            valid_q    <= '0;
            sel_q      <= '0;
            rel_q      <= '0;
            num_free_q <= (IDX_W+1)'(NUM_ENTRIES);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                row_q[i] <= '0;
                lat_q[i] <= '0;
            end
        end else begin
            valid_q    <= (valid_q | alloc_oh) & ~free_oh;
            sel_q      <= (sel_q | grant_oh) & ~free_oh;
            rel_q      <= (rel_q | bcast) & ~free_oh;
            num_free_q <= num_free_q
                        + (IDX_W+1)'(|free_oh)
                        - (IDX_W+1)'(alloc);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc_oh[i]) begin
                    row_q[i] <= new_row;
                    lat_q[i] <= io.disp_latency;
                end else if (free_oh[i]) begin
                    row_q[i] <= '0;
                end else begin
                    row_q[i] <= row_q[i] & ~clear_col;
                end
            end
        end
    end

    // Sticky across flush; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (live && protocol_err) begin
            err_q <= 1'b1;
        end
    end

endmodule
